// File: rtl/tx_dispatch_pkg.sv
// tx_dispatch_pkg
// Shared definitions for the transmit channel dispatcher:
//   - default sizing constants for the channel FIFOs and the burst length
//   - the dispatcher FSM state encoding
//   - onehot(): channel index to write-strobe decode
package tx_dispatch_pkg;

    localparam int NUM_CH_DEF     = 6;
    localparam int DATA_W_DEF     = 8;
    localparam int USDW_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 256;
    localparam int BURST_LEN_DEF  = 16;

    // Channel index width; the dispatcher supports at most 8 channels.
    localparam int CH_IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_BURST = 2'd2,
        ST_DRAIN = 2'd3
    } dispatch_state_e;

    // Decode a channel index to an 8-bit one-hot vector; callers truncate to NUM_CH.
    function automatic logic [7:0] onehot(input logic [CH_IDX_W-1:0] idx);
        onehot = 8'd1 << idx;
    endfunction

endpackage

// File: rtl/tx_channel_dispatch.sv
// tx_channel_dispatch
// Routes a DMA write stream into one of NUM_CH per-channel TX FIFOs in fixed
// bursts of BURST_LEN words. A burst starts only once the selected FIFO has
// room for the whole burst; the channel is latched per burst.
//
// Ports:
//   clk, reset_n     system clock, asynchronous active-low reset
//   active_channel   requested target channel (values >= NUM_CH are ignored)
//   dma_wr_req       DMA presents a word
//   dma_data         DMA write data
//   dma_ready        dispatcher accepts a word this cycle
//   ch_write_req     one-hot write strobes to the channel FIFOs
//   fifo_data        shared write data bus to all channel FIFOs
//   fifo_usdw        packed used-words, channel k at [k*USDW_W +: USDW_W]
//   fifo_wrfull      per-channel FIFO full flags
//   cur_channel      channel latched for the current or last burst
//   busy             FSM is not in IDLE
//   err_clr          clears the sticky error flags
//   ovf_err          sticky: dma_wr_req seen while dma_ready=0
//   drop_err         sticky: an accepted word was dropped on a full FIFO
//   dbg_state        current FSM state (dispatch_state_e encoding)
//
// Handshake: a word transfers in any cycle where dma_wr_req=1 and dma_ready=1.
// dma_ready is decoded from the FSM state only, never from dma_wr_req. The
// accepted word appears on fifo_data with its ch_write_req strobe exactly one
// cycle later.
//
// BURST_LEN must satisfy 1 <= BURST_LEN <= FIFO_DEPTH-1, and NUM_CH <= 8.
module tx_channel_dispatch
    import tx_dispatch_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int USDW_W     = USDW_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int BURST_LEN  = BURST_LEN_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [CH_IDX_W-1:0]        active_channel,
    input  logic                       dma_wr_req,
    input  logic [DATA_W-1:0]          dma_data,
    output logic                       dma_ready,
    output logic [NUM_CH-1:0]          ch_write_req,
    output logic [DATA_W-1:0]          fifo_data,
    input  logic [NUM_CH*USDW_W-1:0]   fifo_usdw,
    input  logic [NUM_CH-1:0]          fifo_wrfull,
    output logic [CH_IDX_W-1:0]        cur_channel,
    output logic                       busy,
    input  logic                       err_clr,
    output logic                       ovf_err,
    output logic                       drop_err,
    output logic [1:0]                 dbg_state
);

    localparam int CNT_W  = $clog2(BURST_LEN + 1);
    localparam int FREE_W = USDW_W + 1;

    localparam logic [CNT_W-1:0]    LAST_CNT   = CNT_W'(BURST_LEN - 1);
    localparam logic [FREE_W-1:0]   FREE_MAX   = FREE_W'(FIFO_DEPTH - 1);
    localparam logic [FREE_W-1:0]   BURST_FREE = FREE_W'(BURST_LEN);
    localparam logic [CH_IDX_W:0]   NUM_CH_EXT = (CH_IDX_W + 1)'(NUM_CH);

    dispatch_state_e       state;
    dispatch_state_e       state_nxt;
    logic [CNT_W-1:0]      burst_cnt;

    logic                  ch_valid;
    logic [USDW_W-1:0]     sel_usdw;
    logic                  sel_full;
    logic [NUM_CH-1:0]     sel_onehot;
    logic [FREE_W-1:0]     free_words;
    logic                  room_ok;
    logic                  accept;
    logic                  last_word;

    // One bit wider than the channel index so NUM_CH = 8 still compares correctly.
    assign ch_valid = ({1'b0, active_channel} < NUM_CH_EXT);

    // Select the latched channel's used-words and full flag.
    always_comb begin
        sel_usdw = '0;
        sel_full = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cur_channel == CH_IDX_W'(k)) begin
                sel_usdw = fifo_usdw[k*USDW_W +: USDW_W];
                sel_full = fifo_wrfull[k];
            end
        end
    end

    assign sel_onehot = NUM_CH'(onehot(cur_channel));

    // One FIFO slot is held in reserve, so the usable space is DEPTH-1 - used.
    // Computed one bit wider than used-words and never negative for legal used-words.
    assign free_words = FREE_MAX - {1'b0, sel_usdw};
    assign room_ok    = (free_words >= BURST_FREE);

    assign accept    = dma_ready && dma_wr_req;
    assign last_word = accept && (burst_cnt == LAST_CNT);

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ch_valid)  state_nxt = ST_ARM;
            ST_ARM:   if (room_ok)   state_nxt = ST_BURST;
            ST_BURST: if (last_word) state_nxt = ST_DRAIN;
            // One idle cycle lets the FIFO used-words catch up with the last write.
            ST_DRAIN: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from state only
    always_comb begin
        dma_ready = (state == ST_BURST);
        busy      = (state != ST_IDLE);
        dbg_state = state;
    end

    // Channel latch, burst counter and registered FIFO-side outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_channel  <= '0;
            burst_cnt    <= '0;
            ch_write_req <= '0;
            fifo_data    <= '0;
        end else begin
            if (state == ST_IDLE && ch_valid) begin
                cur_channel <= active_channel;
            end

            if (state == ST_ARM && room_ok) begin
                burst_cnt <= '0;
            end else if (accept) begin
                burst_cnt <= burst_cnt + 1'b1;
            end

            ch_write_req <= '0;
            if (accept) begin
                fifo_data <= dma_data;
                // A full target FIFO swallows the word, but it still counts
                // toward the burst so the DMA side keeps its framing.
                if (!sel_full) begin
                    ch_write_req <= sel_onehot;
                end
            end
        end
    end

    // Sticky error flags; a set condition beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_err  <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            if (dma_wr_req && !dma_ready) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end

            if (accept && sel_full) begin
                drop_err <= 1'b1;
            end else if (err_clr) begin
                drop_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tx_channel_dispatch.sv
// tb_tx_channel_dispatch
// Directed bench for tx_channel_dispatch. Every word driven into the DUT
// pushes its expected channel strobe, data and write cycle onto exp_q; a
// monitor pops and compares on each observed FIFO write strobe.
module tb_tx_channel_dispatch;
    import tx_dispatch_pkg::*;

    localparam int NUM_CH = 6;
    localparam int DATA_W = 8;
    localparam int USDW_W = 8;
    localparam int BLEN   = 16;
    localparam int ENT_W  = NUM_CH + DATA_W + 32;

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // DUT signals
    logic [2:0]               active_channel = 3'd7;
    logic                     dma_wr_req = 1'b0;
    logic [DATA_W-1:0]        dma_data = '0;
    logic                     dma_ready;
    logic [NUM_CH-1:0]        ch_write_req;
    logic [DATA_W-1:0]        fifo_data;
    logic [NUM_CH*USDW_W-1:0] fifo_usdw = '0;
    logic [NUM_CH-1:0]        fifo_wrfull = '0;
    logic [2:0]               cur_channel;
    logic                     busy;
    logic                     err_clr = 1'b0;
    logic                     ovf_err;
    logic                     drop_err;
    logic [1:0]               dbg_state;

    tx_channel_dispatch dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .active_channel (active_channel),
        .dma_wr_req     (dma_wr_req),
        .dma_data       (dma_data),
        .dma_ready      (dma_ready),
        .ch_write_req   (ch_write_req),
        .fifo_data      (fifo_data),
        .fifo_usdw      (fifo_usdw),
        .fifo_wrfull    (fifo_wrfull),
        .cur_channel    (cur_channel),
        .busy           (busy),
        .err_clr        (err_clr),
        .ovf_err        (ovf_err),
        .drop_err       (drop_err),
        .dbg_state      (dbg_state)
    );

    // scoreboard
    logic [ENT_W-1:0] exp_q[$];
    logic [ENT_W-1:0] ent;
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int wr_cnt = 0;
    int wr_base;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // write monitor: each strobe must match the oldest expected write
    always @(negedge clk) begin
        if (reset_n && ch_write_req != '0) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 64'(ch_write_req), 64'd0);
            end else begin
                ent = exp_q.pop_front();
                check("wr_chan",    64'(ch_write_req), 64'(ent[ENT_W-1 -: NUM_CH]));
                check("wr_data",    64'(fifo_data),    64'(ent[DATA_W+31:32]));
                check("wr_latency", 64'(cyc),          64'(ent[31:0]) + 64'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic set_usdw(input int ch, input logic [USDW_W-1:0] v);
        fifo_usdw[ch*USDW_W +: USDW_W] = v;
    endtask

    task automatic pulse_clr();
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
    endtask

    // Drive n_words to channel ch starting at data base. Word index drop_idx
    // sees its FIFO full; after word index switch_idx-1, active_channel becomes switch_to.
    // Returns on the negedge following the last acceptance.
    task automatic run_burst(input int ch, input logic [7:0] base, input int n_words,
                             input int drop_idx, input int switch_idx, input logic [2:0] switch_to);
        logic [NUM_CH-1:0] oh;
        int i;
        int budget;
        oh = NUM_CH'(1) << ch;
        i = 0;
        budget = 0;
        wr_base = wr_cnt;
        while (i < n_words && budget < 100) begin
            @(negedge clk);
            budget++;
            if (dma_ready) begin
                dma_wr_req  = 1'b1;
                dma_data    = base + 8'(i);
                fifo_wrfull = (i == drop_idx) ? oh : '0;
                if (i != drop_idx) exp_q.push_back({oh, dma_data, 32'(cyc)});
                i++;
                if (i == switch_idx) active_channel = switch_to;
            end else begin
                dma_wr_req = 1'b0;
            end
        end
        @(negedge clk);
        dma_wr_req  = 1'b0;
        fifo_wrfull = '0;
        check("burst_words_driven", 64'(i), 64'(n_words));
    endtask

    task automatic check_writes(input string tag, input int n);
        #1;
        check(tag, 64'(wr_cnt - wr_base), 64'(n));
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_dma_ready", 64'(dma_ready),    64'd0);
        check("rst_wr_req",    64'(ch_write_req), 64'd0);
        check("rst_fifo_data", 64'(fifo_data),    64'd0);
        check("rst_cur_ch",    64'(cur_channel),  64'd0);
        check("rst_busy",      64'(busy),         64'd0);
        check("rst_ovf",       64'(ovf_err),      64'd0);
        check("rst_drop",      64'(drop_err),     64'd0);
        check("rst_state",     64'(dbg_state),    64'(ST_IDLE));
    endtask

    initial begin
        // Test 1: reset, then full burst to channel 2
        #1;
        check_reset_outputs();
        active_channel = 3'd2;
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        check("t1_arm_ready", 64'(dma_ready), 64'd0);
        check("t1_arm_busy",  64'(busy),      64'd1);
        @(negedge clk);
        check("t1_ready_2cyc", 64'(dma_ready), 64'd1);
        run_burst(2, 8'h10, BLEN, -1, -1, 3'd0);
        active_channel = 3'd7;
        check("t1_ready_after", 64'(dma_ready), 64'd0);
        check("t1_state_drain", 64'(dbg_state), 64'(ST_DRAIN));
        check_writes("t1_writes", 16);
        check("t1_no_ovf", 64'(ovf_err), 64'd0);
        wait_neg(2);
        check("t1_idle_busy", 64'(busy), 64'd0);

        // Test 2: ARM waits for room on channel 4
        set_usdw(4, 8'd245);
        active_channel = 3'd4;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t2_hold_arm",   64'(dbg_state), 64'(ST_ARM));
            check("t2_hold_ready", 64'(dma_ready), 64'd0);
        end
        set_usdw(4, 8'd239);
        @(negedge clk);
        check("t2_burst_entered", 64'(dbg_state), 64'(ST_BURST));
        run_burst(4, 8'h40, BLEN, -1, -1, 3'd0);
        active_channel = 3'd7;
        check_writes("t2_writes", 16);
        set_usdw(4, 8'd0);
        wait_neg(2);

        // Test 3: channel change mid-burst applies at the next burst
        active_channel = 3'd1;
        run_burst(1, 8'h20, BLEN, -1, 5, 3'd3);
        check("t3_drain_ready", 64'(dma_ready),   64'd0);
        check("t3_drain_ch",    64'(cur_channel), 64'd1);
        check_writes("t3_writes_ch1", 16);
        @(negedge clk);
        check("t3_gap_idle", 64'(dma_ready), 64'd0);
        @(negedge clk);
        check("t3_gap_arm",  64'(dma_ready),   64'd0);
        check("t3_latch_ch", 64'(cur_channel), 64'd3);
        @(negedge clk);
        check("t3_next_ready", 64'(dma_ready), 64'd1);
        run_burst(3, 8'h30, BLEN, -1, -1, 3'd0);
        active_channel = 3'd7;
        check_writes("t3_writes_ch3", 16);
        wait_neg(2);

        // Test 4: invalid channel stays idle; overflow flag, clear, set-wins
        active_channel = 3'd6;
        wait_neg(3);
        check("t4_idle6_busy",  64'(busy),      64'd0);
        check("t4_idle6_state", 64'(dbg_state), 64'(ST_IDLE));
        active_channel = 3'd7;
        wait_neg(2);
        check("t4_idle7_busy", 64'(busy), 64'd0);
        dma_wr_req = 1'b1;
        @(negedge clk) dma_wr_req = 1'b0;
        check("t4_ovf_set", 64'(ovf_err), 64'd1);
        pulse_clr();
        check("t4_ovf_clr", 64'(ovf_err), 64'd0);
        dma_wr_req = 1'b1;
        err_clr    = 1'b1;
        @(negedge clk);
        dma_wr_req = 1'b0;
        err_clr    = 1'b0;
        check("t4_set_wins", 64'(ovf_err), 64'd1);
        pulse_clr();
        check("t4_ovf_clr2", 64'(ovf_err), 64'd0);

        // Test 5: full FIFO drops word 7 of a channel-0 burst
        active_channel = 3'd0;
        run_burst(0, 8'h50, BLEN, 6, -1, 3'd0);
        active_channel = 3'd7;
        check("t5_drop_err", 64'(drop_err), 64'd1);
        check("t5_ready_end", 64'(dma_ready), 64'd0);
        check_writes("t5_writes", 15);
        pulse_clr();
        check("t5_drop_clr", 64'(drop_err), 64'd0);
        wait_neg(1);

        // Test 6: asynchronous reset mid-burst, then a full burst
        dma_wr_req = 1'b1;
        @(negedge clk) dma_wr_req = 1'b0;
        check("t6_ovf_pre", 64'(ovf_err), 64'd1);
        active_channel = 3'd5;
        run_burst(5, 8'h60, 9, -1, -1, 3'd0);
        check_writes("t6_partial", 9);
        #1 reset_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk) reset_n = 1'b1;
        run_burst(5, 8'h70, BLEN, -1, -1, 3'd0);
        active_channel = 3'd7;
        check_writes("t6_full_after", 16);
        check("t6_ready_end", 64'(dma_ready), 64'd0);
        wait_neg(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_channel_dispatch.md
Name: tx_channel_dispatch

Overview:
- Transmit-side counterpart of the receive channel selector: routes a DMA write stream into one of NUM_CH per-channel transmit FIFOs.
- Transfers in fixed bursts of BURST_LEN words. A burst starts only when the target FIFO has room for the whole burst.
- The channel selection is latched per burst, so a channel change takes effect only at a burst boundary.
- Sits between the DMA write master and the per-channel TX FIFOs.

Parameters:
- NUM_CH, 6, number of channel FIFOs.
- DATA_W, 8, data word width.
- USDW_W, 8, FIFO used-words width.
- FIFO_DEPTH, 256, words per channel FIFO.
- BURST_LEN, 16, words per burst; must satisfy 1 <= BURST_LEN <= FIFO_DEPTH-1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- active_channel  in  3  requested target channel.
- dma_wr_req  in  1  DMA presents a word; the word is accepted only when dma_ready=1.
- dma_data  in  DATA_W  DMA write data.
- dma_ready  out  1  dispatcher accepts a word this cycle.
- ch_write_req  out  NUM_CH  one-hot write strobes to the channel FIFOs.
- fifo_data  out  DATA_W  data to all channel FIFOs (shared bus).
- fifo_usdw  in  NUM_CH*USDW_W  packed used-words; channel k occupies bits [k*USDW_W +: USDW_W].
- fifo_wrfull  in  NUM_CH  per-channel FIFO full flags.
- cur_channel  out  3  channel latched for the current or last burst.
- busy  out  1  1 in any state other than IDLE.
- err_clr  in  1  clears the sticky error flags.
- ovf_err  out  1  sticky: dma_wr_req seen while dma_ready=0.
- drop_err  out  1  sticky: accepted word dropped because the selected FIFO was full.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; burst counter=0.
  - dma_ready=0, ch_write_req=0, fifo_data=0, cur_channel=0, busy=0, ovf_err=0, drop_err=0.
- FSM states: IDLE, ARM, BURST, DRAIN.
- IDLE:
  - If active_channel < NUM_CH, latch cur_channel <= active_channel and go to ARM.
  - Otherwise stay in IDLE.
- ARM:
  - free = FIFO_DEPTH-1 - usdw[cur_channel], computed in USDW_W+1 bits and unsigned.
  - If free >= BURST_LEN, clear the counter and go to BURST.
  - Otherwise stay in ARM, re-checking every cycle.
  - active_channel changes while in ARM are ignored.
- BURST:
  - dma_ready=1, decoded from state only (no combinational path from dma_wr_req).
  - An accepted word is dma_wr_req=1 while dma_ready=1. On acceptance:
    - Next cycle, fifo_data=dma_data and ch_write_req=onehot(cur_channel): fixed latency of 1 cycle.
    - The counter increments.
  - On the BURST_LEN-th accepted word, go to DRAIN; dma_ready is 0 on the following cycle.
- DRAIN: one cycle, so the FIFO used-words reflects the final write before the next ARM check. Then go to IDLE.
- ch_write_req is 0 in every cycle not following an accepted word. At most one bit is ever set.
- drop_err:
  - If fifo_wrfull[cur_channel]=1 in the acceptance cycle, suppress that word's write strobe and set drop_err.
  - The counter still advances; burst length is preserved.
- ovf_err: set on dma_wr_req=1 while dma_ready=0.
- err_clr:
  - Clears ovf_err and drop_err.
  - If err_clr and a set condition occur in the same cycle, set wins.
- Counter width is clog2(BURST_LEN+1). It is never compared beyond BURST_LEN.
- Reset asserted mid-burst aborts the burst immediately; the partial burst is not resumed. The DMA master must restart the burst.
- Back-to-back bursts to the same channel: minimum gap of 3 cycles (DRAIN, IDLE, ARM) with dma_ready=0.

Decomposition:
- Shared package tx_dispatch_pkg holds:
  - FSM state enum (IDLE, ARM, BURST, DRAIN).
  - Default NUM_CH, DATA_W, USDW_W, FIFO_DEPTH and BURST_LEN constants.
  - A onehot function.
- No sub-module is needed. Use a single module with the FSM, counter and output registers.

Test Plan:
1. Reset, then active_channel=2 with fifo_usdw[2]=0 and 16 words 0x10..0x1F held on dma_wr_req -> dma_ready goes high 2 cycles after reset release; ch_write_req=6'b000100 for exactly 16 cycles, each 1 cycle after its acceptance; fifo_data follows 0x10..0x1F; then dma_ready=0.
2. fifo_usdw[4]=245 (free=10 < 16), active_channel=4 -> state holds in ARM with dma_ready=0; drop usdw to 239 (free=16) -> BURST entered next cycle.
3. active_channel switches from 1 to 3 at word 5 of a burst -> all 16 writes go to channel 1 (ch_write_req=6'b000010); the next burst goes to channel 3 (6'b001000).
4. active_channel=6 or 7 -> stays in IDLE with busy=0; dma_wr_req pulse -> ovf_err=1; err_clr -> ovf_err=0 next cycle.
5. fifo_wrfull[0]=1 during word 7 of a channel-0 burst -> that strobe is suppressed, drop_err=1, and 15 writes are issued in total.
6. reset_n pulled low at word 9 -> all outputs reach reset values without a clock edge; after release, the next burst is a full 16 words.
